island_packet_assembler: RTL and testbench
==========================================

# island_packet_assembler

Buffered, back-pressured successor to the single-packet data island assembler in the HDMI TMDS path. It accepts whole packets (24-bit header plus four 56-bit subpackets) through a valid/ready handshake into a `FIFO_DEPTH`-entry queue. It serialises them back-to-back across data-island periods, computing BCH ECC on the fly, and inserts null packets when the queue is empty. Its outputs feed the TERC4 encoders of TMDS channels 0–2.

## Interface
- `FIFO_DEPTH`, default 4 — packet queue entries; power of two, ≥2.
- `NULL_FILL`, default 1 — when the queue is empty at a slot start: 1 sends a null packet; 0 sends nothing and holds `packet_enable` low.
- `clk_pixel`  in  1 — pixel clock; the only clock.
- `reset`  in  1 — synchronous, active-high.
- `in_valid`  in  1 — a packet is presented.
- `in_ready`  out  1 — the queue can accept a packet.
- `in_header`  in  24 — HB0 in bits [7:0], HB1 in [15:8], HB2 in [23:16].
- `in_sub`  in  224 — subpacket k occupies bits [56k+55:56k].
- `enable`  in  1 — high on every pixel of a data-island period.
- `packet_data`  out  9 — TERC4 payload bits (bit map below).
- `packet_enable`  out  1 — first cycle of an emitted packet.
- `packet_null`  out  1 — the packet now being emitted is a null fill.
- `truncated`  out  1 — one-cycle pulse: a packet was cut short.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1 — number of queued packets.

## Operation
- **Handshake**
  - A push happens when `in_valid && in_ready`.
  - `in_ready = (fifo_level != FIFO_DEPTH)`.
  - There is no full-queue bypass: when the queue is full, `in_ready` is low even if a pop happens in the same cycle.
- **Slot counter**
  - 5-bit counter `c`, advanced on each `enable` cycle; wraps 31→0.
  - When `c==0 && enable`, the slot starts:
    - If the queue is non-empty, the head is copied into the shadow register and popped in that same cycle.
    - If the queue is empty and `NULL_FILL=1`, all-zero data is loaded and the slot is marked null.
    - If the queue is empty and `NULL_FILL=0`, the slot is idle: `packet_data=0` and `packet_enable=0` for its 32 cycles.
  - A push and a pop in the same cycle leave `fifo_level` unchanged. A push into an empty queue at a slot start does not make that slot carry the packet.
- **ECC**
  - Five independent 8-bit LFSRs, all cleared at each slot start.
  - Update rule: `e' = (e[0]^b) ? (e>>1)^8'h83 : e>>1`.
  - Header LFSR: absorbs header bit `c` for c=0..23. Its parity bit `c-24` is transmitted for c=24..31.
  - Subpacket LFSRs: each absorbs bits 2c then 2c+1 for c=0..27. Parity bits 2(c-28) and 2(c-28)+1 are transmitted for c=28..31.
- **Output bit map** (for slot position c; `B` is the 32-bit header block, `Sk` is the 64-bit block of subpacket k)
  - bit 0 = `B[c]`
  - bits 4:1 = `S3..S0[2c]`
  - bits 8:5 = `S3..S0[2c+1]`
- **Truncation**
  - Trigger: `enable` deasserts while `c != 0`.
  - Response:
    - `c` resets to 0.
    - The remaining packet bits are discarded; the packet is not re-queued.
    - `truncated` pulses for 1 cycle.
  - When `enable` deasserts with `c==0`, the counter simply holds.

## Timing
- Outputs are registered. The value for enable-cycle k appears on `packet_data` in cycle k+1.
- `packet_enable` and `packet_null` are valid together with bit c=0.
- `packet_null` holds for the whole slot.
- Outputs in cycles after a non-enable cycle:
  - `packet_data=0`.
  - `packet_enable=0`.
  - `packet_null=0`.
- `truncated` asserts in the cycle after the first non-enable cycle that follows a partial slot.
- Push-to-emit latency when the queue is empty and idle: the next slot start, then 1 cycle.
- Reset (synchronous, takes priority over all other activity in that cycle):
  - Queue emptied; `fifo_level=0`.
  - `c=0`.
  - All LFSRs are cleared.
  - `packet_data=0`, `packet_enable=0`, `packet_null=0`, `truncated=0`.
  - `in_ready=1` from the cycle after `reset` is sampled high.
- Reset mid-slot: the slot is abandoned without a `truncated` pulse.

## Test plan
- **Null fill.** `NULL_FILL=1`, empty queue, 32 `enable` cycles.
  - Expected: `packet_enable` and `packet_null` high in cycle 1.
  - Expected: `packet_data=9'h000` for all 32 cycles.
- **Header ECC.** Push header `24'h000001` with all subpackets zero, then 32 `enable` cycles.
  - Expected `packet_data[0]` at c=0..23: 1 then 23 zeros.
  - Expected `packet_data[0]` at c=24..31 (parity 8'h4A, LSB first): 0,1,0,1,0,0,1,0.
  - Expected: `packet_data[8:1]=0` throughout.
- **Back-pressure.** Push 5 packets into a `FIFO_DEPTH=4` queue with `enable` low.
  - Expected: `in_ready` drops once `fifo_level=4`, and the 5th packet is held.
  - Then assert `enable`. Expected: the 5th push completes in the cycle after the first slot start.
  - Expected: the packets are emitted in push order, back-to-back, with `packet_enable` every 32 cycles.
- **Truncation.** Drop `enable` at c=10 with 2 packets queued.
  - Expected: `truncated` pulses once.
  - Expected: the next island starts with the second packet at c=0.
  - Expected: `fifo_level` goes 2→1→0.
- **Simultaneous push and pop.** `fifo_level=2`, push at a slot start.
  - Expected: level stays 2.
- **Reset mid-packet.** Assert `reset` at c=17.
  - Expected next cycle: all outputs 0 and `fifo_level=0`.
  - Expected: a following push is emitted at c=0 of the next island with correct ECC.

Source files
------------

// File: rtl/island_packet_assembler.sv
// Buffered HDMI data-island packet assembler: queues whole packets, serialises them
// into 32-pixel slots with on-the-fly BCH parity, and fills empty slots with nulls.
module island_packet_assembler #(
  parameter int FIFO_DEPTH = 4,
  parameter bit NULL_FILL  = 1'b1
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [23:0]                   in_header,
  input  logic [223:0]                  in_sub,
  input  logic                          enable,
  output logic [8:0]                    packet_data,
  output logic                          packet_enable,
  output logic                          packet_null,
  output logic                          truncated,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_LVL = FIFO_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   LVL_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  logic [23:0]      hdr_mem [FIFO_DEPTH];
  logic [223:0]     sub_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level;

  logic [4:0]       c;
  logic [23:0]      hdr_sh;
  logic [223:0]     sub_sh;
  logic             null_sh;
  logic             idle_sh;
  logic [7:0]       ecc_hdr;
  logic [7:0]       ecc_hdr_nxt;
  logic [3:0][7:0]  ecc_sub;
  logic [3:0][7:0]  ecc_sub_nxt;

  logic             q_empty;
  logic             push;
  logic             pop;
  logic             slot_start;
  logic [23:0]      cur_hdr;
  logic [223:0]     cur_sub;
  logic             cur_null;
  logic             cur_idle;
  logic [31:0]      hdr_blk;
  logic [63:0]      sub_blk;
  logic [7:0]       e_tmp;
  logic [8:0]       word_p0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] e, input logic b);
    return (e[0] ^ b) ? ((e >> 1) ^ 8'h83) : (e >> 1);
  endfunction

  assign q_empty    = (level == '0);
  assign in_ready   = (level != FULL_LVL);
  assign push       = in_valid && in_ready;
  assign slot_start = enable && (c == 5'd0);
  assign pop        = slot_start && !q_empty;
  assign fifo_level = level;

  // At c==0 the head is read straight from the queue; later cycles use the shadow copy
  always_comb begin
    cur_hdr  = hdr_sh;
    cur_sub  = sub_sh;
    cur_null = null_sh;
    cur_idle = idle_sh;
    if (c == 5'd0) begin
      cur_null = q_empty && NULL_FILL;
      cur_idle = q_empty && !NULL_FILL;
      if (q_empty) begin
        cur_hdr = '0;
        cur_sub = '0;
      end else begin
        cur_hdr = hdr_mem[rd_ptr];
        cur_sub = sub_mem[rd_ptr];
      end
    end
  end

  // Stage p0: select payload or parity bits and advance the five BCH LFSRs
  always_comb begin
    hdr_blk     = {8'd0, cur_hdr};
    sub_blk     = '0;
    word_p0     = '0;
    ecc_sub_nxt = ecc_sub;
    e_tmp       = (c == 5'd0) ? 8'd0 : ecc_hdr;
    if (c < 5'd24) begin
      ecc_hdr_nxt = lfsr_step(e_tmp, hdr_blk[c]);
      word_p0[0]  = hdr_blk[c];
    end else begin
      ecc_hdr_nxt = ecc_hdr;
      word_p0[0]  = ecc_hdr[c[2:0]];
    end
    for (int k = 0; k < 4; k++) begin
      sub_blk = {8'd0, cur_sub[56*k +: 56]};
      e_tmp   = (c == 5'd0) ? 8'd0 : ecc_sub[k];
      if (c < 5'd28) begin
        e_tmp          = lfsr_step(e_tmp, sub_blk[{c, 1'b0}]);
        ecc_sub_nxt[k] = lfsr_step(e_tmp, sub_blk[{c, 1'b1}]);
        word_p0[1+k]   = sub_blk[{c, 1'b0}];
        word_p0[5+k]   = sub_blk[{c, 1'b1}];
      end else begin
        word_p0[1+k]   = ecc_sub[k][{c[1:0], 1'b0}];
        word_p0[5+k]   = ecc_sub[k][{c[1:0], 1'b1}];
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (push) begin
      hdr_mem[wr_ptr] <= in_header;
      sub_mem[wr_ptr] <= in_sub;
    end
    if (slot_start) begin
      hdr_sh <= cur_hdr;
      sub_sh <= cur_sub;
    end
  end

  // Stage p1: registered outputs, queue pointers and slot control
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      c             <= '0;
      level         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      ecc_hdr       <= '0;
      ecc_sub       <= '0;
      null_sh       <= 1'b0;
      idle_sh       <= 1'b0;
      packet_data   <= '0;
      packet_enable <= 1'b0;
      packet_null   <= 1'b0;
      truncated     <= 1'b0;
    end else begin
      truncated <= !enable && (c != 5'd0);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (enable) begin
        c             <= c + 5'd1;
        ecc_hdr       <= ecc_hdr_nxt;
        ecc_sub       <= ecc_sub_nxt;
        null_sh       <= cur_null;
        idle_sh       <= cur_idle;
        packet_data   <= cur_idle ? 9'd0 : word_p0;
        packet_enable <= (c == 5'd0) && !cur_idle;
        packet_null   <= cur_null;
      end else begin
        c             <= '0;
        packet_data   <= '0;
        packet_enable <= 1'b0;
        packet_null   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_island_packet_assembler.sv
// Scoreboard bench for island_packet_assembler: expected 32-word slots are queued at push time.
module tb_island_packet_assembler;

  logic         clk_pixel = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [23:0]  in_header;
  logic [223:0] in_sub;
  logic         enable;
  logic [8:0]   packet_data;
  logic         packet_enable;
  logic         packet_null;
  logic         truncated;
  logic [2:0]   fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  logic [287:0] sb[$];

  always #5 clk_pixel = ~clk_pixel;

  island_packet_assembler #(.FIFO_DEPTH(4), .NULL_FILL(1'b1)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_header(in_header), .in_sub(in_sub), .enable(enable), .packet_data(packet_data),
    .packet_enable(packet_enable), .packet_null(packet_null), .truncated(truncated),
    .fifo_level(fifo_level)
  );

  function automatic logic [7:0] bch(input logic [7:0] e, input logic b);
    return (e[0] ^ b) ? ((e >> 1) ^ 8'h83) : (e >> 1);
  endfunction

  // Build the header block B and subpacket blocks Sk, then lay them out per slot position
  function automatic logic [287:0] exp_packet(input logic [23:0] h, input logic [223:0] s);
    logic [7:0]   eh;
    logic [7:0]   es;
    logic [31:0]  blk_b;
    logic [63:0]  blk_s [4];
    logic [287:0] r;
    eh = 8'd0;
    for (int i = 0; i < 24; i++) eh = bch(eh, h[i]);
    blk_b = {eh, h};
    for (int k = 0; k < 4; k++) begin
      es = 8'd0;
      for (int i = 0; i < 56; i++) es = bch(es, s[56*k+i]);
      blk_s[k] = {es, s[56*k +: 56]};
    end
    for (int p = 0; p < 32; p++)
      r[9*p +: 9] = {blk_s[3][2*p+1], blk_s[2][2*p+1], blk_s[1][2*p+1], blk_s[0][2*p+1],
                     blk_s[3][2*p],   blk_s[2][2*p],   blk_s[1][2*p],   blk_s[0][2*p], blk_b[p]};
    return r;
  endfunction

  task automatic clk1();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic rand_pkt(output logic [23:0] h, output logic [223:0] s);
    h = 24'($urandom());
    s = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic push_pkt(input logic [23:0] h, input logic [223:0] s, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1; in_header = h; in_sub = s;
    for (int i = 0; i < 8; i++) begin
      if (!ok) begin
        ok = in_ready;
        clk1();
      end
    end
    in_valid = 1'b0;
    if (ok) sb.push_back(exp_packet(h, s));
  endtask

  // Runs 32 cycles with enable already high and records what the DUT emits
  task automatic capture_slot(input int drop_valid_at, output logic [287:0] w,
                              output logic [31:0] pen, output logic [31:0] pnl,
                              output logic [31:0] rdy, output logic [2:0] lvl_first);
    for (int i = 0; i < 32; i++) begin
      clk1();
      w[9*i +: 9] = packet_data;
      pen[i] = packet_enable;
      pnl[i] = packet_null;
      rdy[i] = in_ready;
      if (i == 0) lvl_first = fifo_level;
      if (i == drop_valid_at) in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; enable = 1'b0; in_header = '0; in_sub = '0;
    clk1(); clk1();
    n_checks++;
    if ({packet_data, packet_enable, packet_null, truncated} !== 12'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 000", {packet_data, packet_enable, packet_null, truncated});
    end
    n_checks++;
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    reset = 1'b0;
    clk1();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_null_fill();
    logic [287:0] w; logic [31:0] pen, pnl, rdy; logic [2:0] lv;
    enable = 1'b1;
    capture_slot(-1, w, pen, pnl, rdy, lv);
    enable = 1'b0;
    n_checks++;
    if (pen !== 32'h1) begin n_fail++; $display("FAIL null_enable: got %h expected 00000001", pen); end
    n_checks++;
    if (pnl !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL null_flag: got %h expected ffffffff", pnl); end
    n_checks++;
    if (w !== 288'd0) begin n_fail++; $display("FAIL null_data: got %h expected 0", w); end
    clk1();
    n_checks++;
    if (packet_null !== 1'b0) begin n_fail++; $display("FAIL null_after: got %b expected 0", packet_null); end
  endtask

  task automatic test_header_ecc();
    logic [287:0] w, exp; logic [31:0] pen, pnl, rdy, col0; logic [2:0] lv; bit ok;
    logic [287:0] upper;
    push_pkt(24'h000001, 224'd0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ecc_push: got ok=%b expected 1", ok); end
    enable = 1'b1;
    capture_slot(-1, w, pen, pnl, rdy, lv);
    enable = 1'b0;
    clk1();
    upper = w;
    for (int p = 0; p < 32; p++) begin
      col0[p] = w[9*p];
      upper[9*p] = 1'b0;
    end
    n_checks++;
    if (col0 !== 32'h4A00_0001) begin n_fail++; $display("FAIL ecc_header_bits: got %h expected 4a000001", col0); end
    n_checks++;
    if (upper !== 288'd0) begin n_fail++; $display("FAIL ecc_sub_bits: got %h expected 0", upper); end
    n_checks++;
    if (pen !== 32'h1 || pnl !== 32'h0) begin
      n_fail++; $display("FAIL ecc_flags: got pen=%h pnull=%h expected 00000001/00000000", pen, pnl);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_checks++;
    if (w !== exp) begin n_fail++; $display("FAIL ecc_packet: got %h expected %h", w, exp); end
  endtask

  task automatic test_back_pressure();
    logic [287:0] w, exp; logic [31:0] pen, pnl, rdy; logic [2:0] lv;
    logic [23:0] h; logic [223:0] s; bit ok;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_pkt(h, s);
      push_pkt(h, s, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL bp_push%0d: got ok=%b expected 1", i, ok); end
    end
    n_checks++;
    if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: got level=%0d ready=%b expected 4/0", fifo_level, in_ready);
    end
    rand_pkt(h, s);
    in_valid = 1'b1; in_header = h; in_sub = s;
    clk1(); clk1();
    n_checks++;
    if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_held: got level=%0d expected 4", fifo_level); end
    sb.push_back(exp_packet(h, s));
    enable = 1'b1;
    capture_slot(1, w, pen, pnl, rdy, lv);
    n_checks++;
    if (lv !== 3'd3 || rdy[1:0] !== 2'b01) begin
      n_fail++; $display("FAIL bp_fifth_push: got level=%0d ready=%b expected 3/01", lv, rdy[1:0]);
    end
    n_checks++;
    if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_level_after: got %0d expected 4", fifo_level); end
    for (int n = 0; n < 5; n++) begin
      if (n != 0) capture_slot(-1, w, pen, pnl, rdy, lv);
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_checks++;
      if (w !== exp || pen !== 32'h1 || pnl !== 32'h0) begin
        n_fail++; $display("FAIL bp_slot%0d: got pen=%h data=%h expected pen=00000001 data=%h", n, pen, w, exp);
      end
    end
    enable = 1'b0;
    clk1();
    n_checks++;
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL bp_drained: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_truncation();
    logic [287:0] w, exp; logic [31:0] pen, pnl, rdy; logic [2:0] lv;
    logic [23:0] h; logic [223:0] s; bit ok;
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_pkt(h, s); push_pkt(h, s, ok); end
    n_checks++;
    if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL tr_level_start: got %0d expected 2", fifo_level); end
    enable = 1'b1;
    repeat (10) clk1();
    enable = 1'b0;
    clk1();
    n_checks++;
    if (truncated !== 1'b1 || packet_data !== 9'd0 || packet_enable !== 1'b0 || fifo_level !== 3'd1) begin
      n_fail++; $display("FAIL tr_pulse: got trunc=%b data=%h pen=%b level=%0d expected 1/000/0/1",
                         truncated, packet_data, packet_enable, fifo_level);
    end
    clk1();
    n_checks++;
    if (truncated !== 1'b0) begin n_fail++; $display("FAIL tr_single: got %b expected 0", truncated); end
    if (sb.size() != 0) void'(sb.pop_front());
    enable = 1'b1;
    capture_slot(-1, w, pen, pnl, rdy, lv);
    enable = 1'b0;
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_checks++;
    if (w !== exp || pen !== 32'h1 || lv !== 3'd0) begin
      n_fail++; $display("FAIL tr_next: got pen=%h level=%0d data=%h expected 00000001/0/%h", pen, lv, w, exp);
    end
    clk1();
  endtask

  task automatic test_simultaneous();
    logic [287:0] w, exp; logic [31:0] pen, pnl, rdy; logic [2:0] lv;
    logic [23:0] h; logic [223:0] s; bit ok;
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_pkt(h, s); push_pkt(h, s, ok); end
    rand_pkt(h, s);
    in_valid = 1'b1; in_header = h; in_sub = s;
    sb.push_back(exp_packet(h, s));
    enable = 1'b1;
    capture_slot(0, w, pen, pnl, rdy, lv);
    n_checks++;
    if (lv !== 3'd2) begin n_fail++; $display("FAIL sim_level: got %0d expected 2", lv); end
    for (int n = 0; n < 3; n++) begin
      if (n != 0) capture_slot(-1, w, pen, pnl, rdy, lv);
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_checks++;
      if (w !== exp || pen !== 32'h1) begin
        n_fail++; $display("FAIL sim_slot%0d: got pen=%h data=%h expected 00000001/%h", n, pen, w, exp);
      end
    end
    enable = 1'b0;
    clk1();
  endtask

  task automatic test_reset_mid();
    logic [287:0] w, exp; logic [31:0] pen, pnl, rdy; logic [2:0] lv;
    logic [23:0] h; logic [223:0] s; bit ok;
    enable = 1'b0;
    rand_pkt(h, s); push_pkt(h, s, ok);
    enable = 1'b1;
    repeat (17) clk1();
    reset = 1'b1;
    clk1();
    n_checks++;
    if ({packet_data, packet_enable, packet_null, truncated} !== 12'd0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL rm_outputs: got %h level=%0d expected 000/0",
                         {packet_data, packet_enable, packet_null, truncated}, fifo_level);
    end
    reset = 1'b0; enable = 1'b0;
    clk1();
    n_checks++;
    if (truncated !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rm_no_trunc: got trunc=%b ready=%b expected 0/1", truncated, in_ready);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    rand_pkt(h, s); push_pkt(h, s, ok);
    enable = 1'b1;
    capture_slot(-1, w, pen, pnl, rdy, lv);
    enable = 1'b0;
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_checks++;
    if (w !== exp || pen !== 32'h1 || pnl !== 32'h0) begin
      n_fail++; $display("FAIL rm_next: got pen=%h data=%h expected 00000001/%h", pen, w, exp);
    end
    clk1();
  endtask

  initial begin
    test_reset();
    test_null_fill();
    test_header_ecc();
    test_back_pressure();
    test_truncation();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
